// File: rtl/apb_master_nslv.sv
// APB master bridge: valid/ready request port to APB SETUP/ACCESS transfers on NUM_SLV slaves.
// Optional APB_TIMEOUT_EN: abort an ACCESS phase that sees no PREADY within TIMEOUT cycles.
module apb_master_nslv #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (NUM_SLV < 1 || NUM_SLV > 16 || SEL_W > ADDR_W || TIMEOUT < 2) begin : g_bad_params
        $error("apb_master_nslv: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [SEL_W-1:0] sel_idx;
    logic             dec_err;
    logic             accept;
    logic             launch;
    logic             complete;
    logic             timeout_hit;
    // A decode-error request accepted in a completion cycle still owes its response.
    logic             err_pending;

    if (NUM_SLV == 1) begin : g_single
        assign sel_idx = '0;
        assign dec_err = 1'b0;
    end else begin : g_multi
        localparam logic [SEL_W:0] NUM_SLV_V = (SEL_W + 1)'(NUM_SLV);
        assign sel_idx = req_addr[ADDR_W-1 -: SEL_W];
        assign dec_err = {1'b0, sel_idx} >= NUM_SLV_V;
    end

    function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == i[SEL_W-1:0]) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // NOTE: always_comb assigns every output unconditionally first, so no latch can be inferred.
    always_comb begin
        req_ready = 1'b0;
        if (state == ST_IDLE) req_ready = 1'b1;
        else if (state == ST_ACCESS && PREADY) req_ready = 1'b1;
    end

    assign accept   = req_valid && req_ready;
    assign launch   = accept && !dec_err;
    assign complete = (state == ST_ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // ACCESS is only ever entered from SETUP, so clearing there clears on entry.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == ST_ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            err_pending <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;

            case (state)
                ST_IDLE: begin
                    err_pending <= 1'b0;
                    if (err_pending) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        // A second decode error arriving now must wait one more cycle.
                        if (accept && dec_err) err_pending <= 1'b1;
                    end else if (accept && dec_err) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (complete) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                        PENABLE     <= 1'b0;
                        PSEL        <= '0;
                        state       <= ST_IDLE;
                        err_pending <= accept && dec_err;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        PENABLE   <= 1'b0;
                        PSEL      <= '0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase

            // A valid accept from IDLE or a completion cycle overrides the transitions above.
            if (launch) begin
                PADDR   <= req_addr;
                PWRITE  <= req_write;
                PWDATA  <= req_wdata;
                PSEL    <= onehot(sel_idx);
                PENABLE <= 1'b0;
                state   <= ST_SETUP;
            end
        end
    end

endmodule
